grid_board: RTL and testbench
=============================

# grid_board

Parametrised N×N game-board state engine replacing the fixed 4×4 array of per-cell `x` instances. It holds W-bit cell states, applies a "fire" move to every cell of one selected row or column, and detects the win condition (all cells equal). It sits between the debounced switch/button inputs and the colour decoders, VGA display and win-sound logic. The packed board bus keeps the existing cell ordering.

## Interface
Parameters:
- `N`, 4: board dimension; N×N cells, 2 ≤ N ≤ 16.
- `W`, 2: bits per cell; cell values wrap modulo 2^W.
- `CW`, 8: move-counter width.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `fire`  in  1  debounced fire button, level; rising edge requests a move.
- `sel`  in  N  row/column select switches; must be one-hot.
- `nRow`  in  1  0 = `sel` selects a row, 1 = `sel` selects a column.
- `add_n`  in  1  0 = increment cells, 1 = decrement cells; sampled on the fire edge.
- `board`  out  N*N*W  cell (r,c) at `board[(r*N+c)*W +: W]`.
- `error`  out  1  registered; 1 when `sel` is not exactly one-hot.
- `busy`  out  1  move in progress.
- `win`  out  1  sticky; all cells equal after a move.
- `move_count`  out  CW  completed moves (see Configuration).

## Operation
- Reset values: all cells 0, `error` 0, `busy` 0, `win` 0, `move_count` 0, FSM in IDLE, fire history 0.
- Fire edge: `fire`=1 while the registered previous `fire`=0. It is detected in every state.
- FSM states:
  - IDLE: on a fire edge with `error`=0 and `win`=0, latch line index (position of the `sel` bit), `nRow` and `add_n`. Clear k and go to SWEEP. Otherwise stay in IDLE.
  - SWEEP: update one cell per cycle.
    - Row move: cell (line,k). Column move: cell (k,line).
    - Update is +1 mod 2^W when latched `add_n`=0, −1 mod 2^W when 1.
    - When k=N−1, go to CHECK; otherwise k+1.
  - CHECK: one cycle. Set `win` if every cell equals cell (0,0). Increment `move_count`. Return to IDLE.
- Fire edges while `busy`=1 are dropped, not queued.
- Changes to `sel`, `nRow` or `add_n` during SWEEP do not affect the move in progress.
- `error` is recomputed every cycle from `sel` (zero or more than one bit set gives 1). A fire edge while `error`=1 is ignored.
- `win`=1 locks the board: further fire edges are ignored until reset.
- `win` is evaluated only in CHECK, so the all-zero reset board does not report a win.
- Reset asserted mid-sweep aborts the move immediately. Cells already updated return to 0 with everything else.

## Timing
- Fire edge sampled at rising clock edge t (cycle t shows `fire`=1, previous 0).
- `busy`=1 from cycle t+1 through t+N+1.
- Cell k of the line changes at the clock edge ending cycle t+1+k. The whole line is updated by cycle t+N+1.
- CHECK occupies cycle t+N+1. `win` and `move_count` update at the end of that cycle and are visible in t+N+2, together with `busy`=0.
- Move latency is N+1 cycles. The earliest next accepted edge is at cycle t+N+2, which needs `fire` low for at least one sampled cycle in between.
- `error` lags `sel` by one cycle.
- `board` is driven directly from registers, with no combinational path from inputs.

## Configuration
- `GRID_MOVE_COUNTER_EN` defined: `move_count` increments once per completed move in CHECK and saturates at 2^CW−1 (no wrap).
- `GRID_MOVE_COUNTER_EN` undefined: no counter register is built and `move_count` is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then idle: `board`=0, `win`=0, `busy`=0, `error`=1 (sel=0). Set `sel`=4'b0100 → `error`=0 one cycle later.
- N=4, W=2, row move, increment:
  - Stimulus: `nRow`=0, `sel`=4'b0001, `add_n`=0, one fire pulse.
  - Response: `busy` high for 5 cycles; `board[7:0]`=8'h55; all other bits 0; `move_count`=1; `win`=0.
- Column move, decrement, with wrap:
  - Stimulus: from reset, `nRow`=1, `sel`=4'b1000, `add_n`=1, fire.
  - Response: cells (r,3)=3 for all r; all other cells 0.
- Illegal selection and busy drops:
  - `sel`=4'b0011 with fire → no board change, `move_count` unchanged.
  - A second fire edge during SWEEP → dropped; exactly one move counted.
- Win and lock:
  - Stimulus: from reset, fire rows 0..3 with increment (4 moves).
  - Response: after the 4th CHECK all cells are 1 and `win`=1. A 5th fire → board unchanged.
- Reset mid-sweep: assert `reset` low during the 3rd SWEEP cycle → `board`=0, `busy`=0, `move_count`=0 asynchronously. With the macro undefined, `move_count` stays 0 throughout.

Source files
------------

// File: rtl/grid_board.sv
`default_nettype none
// grid_board: N x N board of W-bit cells; a fire edge sweeps +/-1 across one row or column, then checks for a win.
// Optional saturating move counter is built only when GRID_MOVE_COUNTER_EN is defined.
module grid_board #(
   parameter int N  = 4,
   parameter int W  = 2,
   parameter int CW = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             fire,
   input  logic [N-1:0]     sel,
   input  logic             nRow,
   input  logic             add_n,
   output logic [N*N*W-1:0] board,
   output logic             error,
   output logic             busy,
   output logic             win,
   output logic [CW-1:0]    move_count
);

   localparam int LW = (N > 1) ? $clog2(N) : 1;
   localparam logic [LW-1:0] c_LAST = LW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_CHECK = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_fire_d;
   logic             r_error;
   logic             r_win;
   logic             r_col;
   logic             r_dec;
   logic [LW-1:0]    r_line;
   logic [LW-1:0]    r_k;
   logic [N*N*W-1:0] r_board;
   logic [LW-1:0]    w_sel_idx;
   logic             w_fire_edge;
   logic             w_sel_ok;
   logic             w_start;
   logic             w_all_eq;
   logic [W-1:0]     w_delta;
   int               w_cell;

   assign w_fire_edge = fire & ~r_fire_d;
   assign w_sel_ok    = (sel != '0) && ((sel & (sel - N'(1))) == '0);
   assign w_delta     = r_dec ? {W{1'b1}} : W'(1);

   always_comb begin
      w_sel_idx = '0;
      for (int i = 0; i < N; i++)
         if (sel[i]) w_sel_idx = LW'(i);
   end

   // Flat cell index of the cell touched this sweep cycle
   always_comb begin
      if (r_col) w_cell = int'(r_k) * N + int'(r_line);
      else       w_cell = int'(r_line) * N + int'(r_k);
   end

   always_comb begin
      w_all_eq = 1'b1;
      for (int i = 1; i < N * N; i++)
         if (r_board[i*W +: W] != r_board[W-1:0]) w_all_eq = 1'b0;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_fire_edge && !r_error && !r_win) begin
               w_start     = 1'b1;
               w_state_nxt = S_SWEEP;
            end
         end
         S_SWEEP: begin
            if (r_k == c_LAST) w_state_nxt = S_CHECK;
         end
         S_CHECK: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fire_d <= 1'b0;
         r_error  <= 1'b0;
         r_win    <= 1'b0;
         r_col    <= 1'b0;
         r_dec    <= 1'b0;
         r_line   <= '0;
         r_k      <= '0;
         r_board  <= '0;
      end else begin
         r_fire_d <= fire;
         r_error  <= ~w_sel_ok;
         if (w_start) begin
            r_line <= w_sel_idx;
            r_col  <= nRow;
            r_dec  <= add_n;
            r_k    <= '0;
         end
         if (r_state == S_SWEEP) begin
            r_k <= r_k + LW'(1);
            for (int i = 0; i < N * N; i++)
               if (i == w_cell) r_board[i*W +: W] <= r_board[i*W +: W] + w_delta;
         end
         if (r_state == S_CHECK && w_all_eq) r_win <= 1'b1;
      end
   end

`ifdef GRID_MOVE_COUNTER_EN
   logic [CW-1:0] r_move_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_move_count <= '0;
      else if (r_state == S_CHECK && r_move_count != {CW{1'b1}})
         r_move_count <= r_move_count + CW'(1);
   end

   assign move_count = r_move_count;
`else
   assign move_count = '0;
`endif

   assign board = r_board;
   assign error = r_error;
   assign busy  = (r_state != S_IDLE);
   assign win   = r_win;

endmodule
`default_nettype wire

// File: tb/tb_grid_board.sv
`default_nettype none
// tb_grid_board: scoreboard bench for grid_board at N=4, W=2; each accepted move queues its expected
// board/win/move_count, and a monitor compares when busy falls.
module tb_grid_board;
   localparam int N  = 4;
   localparam int W  = 2;
   localparam int CW = 8;
`ifdef GRID_MOVE_COUNTER_EN
   localparam bit MC_EN = 1'b1;
`else
   localparam bit MC_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             fire = 1'b0;
   logic             nRow = 1'b0;
   logic             add_n = 1'b0;
   logic [N-1:0]     sel = '0;
   logic [N*N*W-1:0] board;
   logic             error;
   logic             busy;
   logic             win;
   logic [CW-1:0]    move_count;

   typedef struct {
      logic [31:0] board;
      logic [7:0]  mc;
      logic        win;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   grid_board #(.N(N), .W(W), .CW(CW)) dut (
      .clk(clk), .reset(reset), .fire(fire), .sel(sel), .nRow(nRow), .add_n(add_n),
      .board(board), .error(error), .busy(busy), .win(win), .move_count(move_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] mc_of(input int n);
      return MC_EN ? 8'(n) : 8'd0;
   endfunction

   task automatic push(input logic [31:0] b, input int n, input logic w);
      exp_t e;
      e.board = b;
      e.mc    = mc_of(n);
      e.win   = w;
      sb.push_back(e);
   endtask

   task automatic do_fire(input logic [N-1:0] s, input logic r, input logic a);
      @(negedge clk);
      sel = s; nRow = r; add_n = a;
      repeat (2) @(negedge clk);
      fire = 1'b1;
      @(negedge clk);
      fire = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL move_timeout: pending %0d required 0", sb.size());
         sb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      fire  = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin : monitor
      logic prev_busy;
      int   blen;
      exp_t e;
      prev_busy = 1'b0;
      blen      = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            prev_busy = 1'b0;
            blen      = 0;
         end else begin
            if (busy) begin
               blen++;
            end else if (prev_busy) begin
               if (sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_move: got board %h required no move", board);
               end else begin
                  e = sb.pop_front();
                  chk("move_board", board, e.board);
                  chk("move_count", 32'(move_count), 32'(e.mc));
                  chk("move_win", 32'(win), 32'(e.win));
                  chk("busy_len", 32'(blen), 32'(N + 1));
               end
               blen = 0;
            end
            prev_busy = busy;
         end
      end
   end

   initial begin : stim
      logic [31:0] win_tbl [4];
      logic [N-1:0] s;
      win_tbl = '{32'h0000_0055, 32'h0000_5555, 32'h0055_5555, 32'h5555_5555};

      // Reset and idle state
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("reset_board", board, 32'h0);
      chk("reset_win", 32'(win), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_mc", 32'(move_count), 32'h0);
      chk("error_sel0", 32'(error), 32'h1);
      sel = 4'b0100;
      #1;
      chk("error_lag", 32'(error), 32'h1);
      @(negedge clk);
      chk("error_clear", 32'(error), 32'h0);

      // Row 0 increment
      push(32'h0000_0055, 1, 1'b0);
      do_fire(4'b0001, 1'b0, 1'b0);
      wait_done();

      // Column 3 decrement wraps to 3
      do_reset();
      push(32'hC0C0_C0C0, 1, 1'b0);
      do_fire(4'b1000, 1'b1, 1'b1);
      wait_done();

      // Illegal selection ignored
      do_fire(4'b0011, 1'b0, 1'b0);
      repeat (8) @(negedge clk);
      chk("illegal_board", board, 32'hC0C0_C0C0);
      chk("illegal_mc", 32'(move_count), 32'(mc_of(1)));
      chk("illegal_error", 32'(error), 32'h1);
      chk("illegal_busy", 32'(busy), 32'h0);

      // Second fire edge during SWEEP is dropped; input changes do not disturb the move
      push(32'hC0C0_C015, 2, 1'b0);
      do_fire(4'b0001, 1'b0, 1'b0);
      fire = 1'b1; sel = 4'b0010; nRow = 1'b1; add_n = 1'b1;
      @(negedge clk);
      fire = 1'b0;
      wait_done();

      // Four row increments reach the all-ones win board
      do_reset();
      for (int i = 0; i < 4; i++) begin
         s = N'(1 << i);
         push(win_tbl[i], i + 1, (i == 3));
         do_fire(s, 1'b0, 1'b0);
         wait_done();
      end
      do_fire(4'b0010, 1'b0, 1'b0);
      repeat (8) @(negedge clk);
      chk("lock_board", board, 32'h5555_5555);
      chk("lock_win", 32'(win), 32'h1);
      chk("lock_mc", 32'(move_count), 32'(mc_of(4)));
      chk("lock_busy", 32'(busy), 32'h0);

      // Reset asserted in the third sweep cycle
      do_reset();
      do_fire(4'b0001, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("pre_abort_board", board, 32'h0000_0005);
      chk("pre_abort_busy", 32'(busy), 32'h1);
      reset = 1'b0;
      #1;
      chk("abort_board", board, 32'h0);
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_mc", 32'(move_count), 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("final_sb_empty", 32'(sb.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
